// File: rtl/ttlock_key_scanner_if.sv
// Query/response channel between the key scanner (master) and the oracle side (slave).
// One query is outstanding at a time; the response carries both oracle and stripped outputs.
interface ttlock_key_scanner_if #(
   parameter int unsigned WINPUT = 32
);
   logic              q_valid;
   logic              q_ready;
   logic [WINPUT-1:0] q_in;
   logic              r_valid;
   logic              r_oracle;
   logic              r_stripped;

   modport master (
      output q_valid, q_in,
      input  q_ready, r_valid, r_oracle, r_stripped
   );

   modport slave (
      input  q_valid, q_in,
      output q_ready, r_valid, r_oracle, r_stripped
   );
endinterface

// File: rtl/ttlock_key_scanner.sv
// Sweeps protected-input patterns against an activated oracle and captures the first pattern
// whose oracle output differs from the stripped-DUT output as the recovered key.
module ttlock_key_scanner #(
   parameter int unsigned WKEY    = 32,
   parameter int unsigned WINPUT  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WKEY-1:0]      start_pat_i,
   input  logic [WINPUT-1:0]    base_in_i,
   ttlock_key_scanner_if.master bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 found_o,
   output logic                 timeout_err_o,
   output logic [WKEY-1:0]      key_out_o
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
   // Clears the protected bit positions so the base can be OR-ed with the pattern.
   localparam logic [WINPUT-1:0] BaseMask = ~(WINPUT'({WKEY{1'b1}}));

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [WKEY-1:0]   pat_q, pat_d;
   logic [WINPUT-1:0] base_q, base_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [WKEY-1:0]   key_q, key_d;
   logic              found_q, found_d;
   logic              terr_q, terr_d;
   logic              q_valid_q, q_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pat_q     <= '0;
         base_q    <= '0;
         timer_q   <= '0;
         key_q     <= '0;
         found_q   <= 1'b0;
         terr_q    <= 1'b0;
         q_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         base_q    <= base_d;
         timer_q   <= timer_d;
         key_q     <= key_d;
         found_q   <= found_d;
         terr_q    <= terr_d;
         q_valid_q <= q_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      base_d  = base_q;
      timer_d = timer_q;
      key_d   = key_q;
      found_d = found_q;
      terr_d  = terr_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StIssue;
               pat_d   = start_pat_i;
               base_d  = base_in_i & BaseMask;
               found_d = 1'b0;
               terr_d  = 1'b0;
            end
         end
         StIssue: begin
            if (bus.q_ready) begin
               state_d = StWait;
               timer_d = '0;
            end
         end
         StWait: begin
            timer_d = timer_q + 1'b1;
            // A response in the expiry cycle takes priority over the timeout.
            if (bus.r_valid) begin
               if (bus.r_oracle != bus.r_stripped) begin
                  state_d = StDone;
                  key_d   = pat_q;
                  found_d = 1'b1;
               end else if (&pat_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
                  pat_d   = pat_q + 1'b1;
               end
            end else if (timer_q == TimerLast) begin
               state_d = StDone;
               terr_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      q_valid_d = (state_d == StIssue);
      busy_d    = (state_d == StIssue) || (state_d == StWait);
      done_d    = (state_d == StDone);
   end

   assign bus.q_valid   = q_valid_q;
   assign bus.q_in      = base_q | WINPUT'(pat_q);
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign found_o       = found_q;
   assign timeout_err_o = terr_q;
   assign key_out_o     = key_q;

endmodule

// File: tb/tb_ttlock_key_scanner.sv
// Drives directed and randomized sweeps against a behavioural oracle and checks every query,
// the result flags and the timing rules against a pattern-level model.
module tb_ttlock_key_scanner;
   localparam int unsigned WKEY    = 4;
   localparam int unsigned WINPUT  = 6;
   localparam int unsigned TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic [WKEY-1:0]   start_pat_i = '0;
   logic [WINPUT-1:0] base_in_i = '0;
   logic              busy_o, done_o, found_o, timeout_err_o;
   logic [WKEY-1:0]   key_out_o;

   int checks = 0;
   int failures = 0;
   logic [WKEY-1:0] exp_key_q = '0;

   always #5 clk = ~clk;

   ttlock_key_scanner_if #(.WINPUT(WINPUT)) qif ();

   ttlock_key_scanner #(
      .WKEY   (WKEY),
      .WINPUT (WINPUT),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .start_pat_i  (start_pat_i),
      .base_in_i    (base_in_i),
      .bus          (qif.master),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .found_o      (found_o),
      .timeout_err_o(timeout_err_o),
      .key_out_o    (key_out_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_q_valid", 32'(qif.q_valid), 32'd0);
      chk("rst_q_in", 32'(qif.q_in), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_found", 32'(found_o), 32'd0);
      chk("rst_timeout", 32'(timeout_err_o), 32'd0);
      chk("rst_key", 32'(key_out_o), 32'd0);
      start_i     = 1'b0;
      qif.q_ready = 1'b0;
      qif.r_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      exp_key_q = '0;
   endtask

   // rdy_mode: 0 always ready, 1 random, 2 five stall cycles per query.
   task automatic run_sweep(input logic [3:0] sp, input logic [5:0] base, input logic [3:0] key,
                            input int lat, input int rdy_mode, input bit no_resp,
                            input bit disturb, input int abort_after);
      int         hs = 0;
      int         resp_cd = -1;
      int         cyc = 0;
      int         hs_cycle = 0;
      int         stall_left = 5;
      int         exp_hs;
      logic [5:0] prev_qin = '0;
      logic [3:0] exp_pat = sp;
      logic [3:0] resp_pat = '0;
      logic [3:0] last;
      bit         prev_stall = 1'b0;
      bit         expect_issue = 1'b0;
      bit         expect_wait = 1'b0;
      bit         finished = 1'b0;
      bit         exp_found;
      logic       f;

      exp_found = !no_resp && (key >= sp);
      last      = (key >= sp) ? key : 4'hF;
      exp_hs    = no_resp ? 1 : int'(last) - int'(sp) + 1;

      @(negedge clk);
      start_pat_i = sp;
      base_in_i   = base;
      start_i     = 1'b1;
      @(negedge clk);
      start_i     = 1'b0;
      start_pat_i = 4'($urandom);
      base_in_i   = 6'($urandom);
      chk("start_busy", 32'(busy_o), 32'd1);
      chk("start_done", 32'(done_o), 32'd0);

      while (!finished && cyc < 2000) begin
         qif.r_valid = 1'b0;
         start_i     = 1'b0;
         if (expect_issue) chk("reissue_next_cycle", 32'(qif.q_valid), 32'd1);
         if (expect_wait) chk("q_valid_drops", 32'(qif.q_valid), 32'd0);
         expect_issue = 1'b0;
         expect_wait  = 1'b0;
         if (prev_stall && qif.q_valid) chk("stall_q_in_stable", 32'(qif.q_in), 32'(prev_qin));
         if (done_o) begin
            finished = 1'b1;
            if (no_resp) chk("timeout_latency", 32'(cyc - hs_cycle), 32'(TIMEOUT + 1));
         end else begin
            if (resp_cd > 0) begin
               resp_cd--;
               if (resp_cd == 0) begin
                  f              = 1'($urandom);
                  qif.r_valid    = 1'b1;
                  qif.r_stripped = f;
                  qif.r_oracle   = f ^ (resp_pat == key);
                  if (resp_pat != key && resp_pat != 4'hF) expect_issue = 1'b1;
               end
            end
            if (disturb && !qif.r_valid) begin
               if (qif.q_valid && $urandom_range(0, 1) == 1) begin
                  qif.r_valid    = 1'b1;
                  qif.r_oracle   = 1'b1;
                  qif.r_stripped = 1'b0;
               end else if (!qif.q_valid && busy_o && $urandom_range(0, 2) == 0) begin
                  start_i     = 1'b1;
                  start_pat_i = 4'($urandom);
               end
            end
            case (rdy_mode)
               0: qif.q_ready = 1'b1;
               1: qif.q_ready = 1'($urandom);
               default: begin
                  if (stall_left > 0) begin
                     qif.q_ready = 1'b0;
                     if (qif.q_valid) stall_left--;
                  end else begin
                     qif.q_ready = 1'b1;
                  end
               end
            endcase
            if (qif.q_valid && qif.q_ready) begin
               chk("q_in_order", 32'(qif.q_in), 32'({base[5:4], exp_pat}));
               hs++;
               resp_pat    = exp_pat;
               exp_pat     = exp_pat + 1'b1;
               resp_cd     = no_resp ? -1 : lat;
               expect_wait = 1'b1;
               hs_cycle    = cyc;
               stall_left  = 5;
            end
            prev_stall = qif.q_valid && !qif.q_ready;
            prev_qin   = qif.q_in;
         end
         if (abort_after != 0 && hs == abort_after) begin
            @(negedge clk);
            return;
         end
         @(negedge clk);
         cyc++;
      end

      qif.r_valid = 1'b0;
      start_i     = 1'b0;
      if (exp_found) exp_key_q = key;
      chk("sweep_bounded", 32'(finished), 32'd1);
      chk("done", 32'(done_o), 32'd1);
      chk("found", 32'(found_o), 32'(exp_found));
      chk("key_out", 32'(key_out_o), 32'(exp_key_q));
      chk("timeout_err", 32'(timeout_err_o), 32'(no_resp));
      chk("handshakes", 32'(hs), 32'(exp_hs));
      chk("idle_busy", 32'(busy_o), 32'd0);
      chk("idle_q_valid", 32'(qif.q_valid), 32'd0);
   endtask

   initial begin
      qif.q_ready    = 1'b0;
      qif.r_valid    = 1'b0;
      qif.r_oracle   = 1'b0;
      qif.r_stripped = 1'b0;
      do_reset();

      // Key 0xA from pattern 0: eleven queries 0x20..0x2A.
      run_sweep(4'h0, 6'b10_0000, 4'hA, 2, 0, 1'b0, 1'b0, 0);
      // Key below start: sweep 5..F runs off the top without a hit.
      do_reset();
      run_sweep(4'h5, 6'b10_0000, 4'h3, 2, 0, 1'b0, 1'b0, 0);
      // Silent oracle: timeout after TIMEOUT cycles in WAIT; a late response is dropped.
      do_reset();
      run_sweep(4'h0, 6'b01_0101, 4'h4, 2, 0, 1'b1, 1'b0, 0);
      qif.r_valid    = 1'b1;
      qif.r_oracle   = 1'b1;
      qif.r_stripped = 1'b0;
      @(negedge clk);
      qif.r_valid = 1'b0;
      @(negedge clk);
      chk("late_resp_found", 32'(found_o), 32'd0);
      chk("late_resp_done", 32'(done_o), 32'd1);
      // Backpressure, plus a response landing exactly in the expiry cycle.
      do_reset();
      run_sweep(4'hC, 6'b11_0000, 4'hE, TIMEOUT, 2, 1'b0, 1'b0, 0);
      // Reset mid-WAIT, then a fresh sweep.
      do_reset();
      run_sweep(4'h0, 6'b10_0000, 4'h9, 2, 0, 1'b0, 1'b0, 3);
      do_reset();
      run_sweep(4'h0, 6'b10_0000, 4'h2, 2, 0, 1'b0, 1'b0, 0);
      // Restart from DONE with ignored start pulses and spurious responses.
      run_sweep(4'h0, 6'b01_0000, 4'h7, 3, 0, 1'b0, 1'b1, 0);
      // Single-query sweeps from the top pattern.
      do_reset();
      run_sweep(4'hF, 6'b11_1111, 4'hF, 1, 0, 1'b0, 1'b0, 0);
      do_reset();
      run_sweep(4'hF, 6'b00_0000, 4'h0, 1, 0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         do_reset();
         run_sweep(4'($urandom), 6'($urandom), 4'($urandom), int'($urandom_range(1, TIMEOUT)),
                   1, 1'b0, 1'($urandom), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
